// File: rtl/lagarto_l15_req_buffer.sv
// Request FIFO between the Lagarto core and the OpenPiton L1.5, with a cap on
// acked requests that are still waiting for a return.
module lagarto_l15_req_buffer #(
    parameter int unsigned DataW          = 128,
    parameter int unsigned Depth          = 4,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 core_req_valid_i,
    output logic                                 core_req_ready_o,
    input  logic [DataW-1:0]                     core_req_data_i,
    output logic                                 l15_val_o,
    output logic [DataW-1:0]                     l15_data_o,
    input  logic                                 l15_ack_i,
    input  logic                                 l15_rtrn_val_i,
    output logic [$clog2(Depth+1)-1:0]           count_o,
    output logic [$clog2(MaxOutstanding+1)-1:0]  outstanding_o,
    output logic                                 err_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam int unsigned OutW = $clog2(MaxOutstanding + 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(Depth);
    localparam logic [OutW-1:0] MaxOut  = OutW'(MaxOutstanding);

    logic [DataW-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [OutW-1:0]  outstanding_q, outstanding_d;
    logic             err_q, err_d;

    logic enq, deq, rtrn_ok, rtrn_err;

    // Handshake qualifiers depend on registered state only, so neither
    // ready nor val has a combinational path from any input.
    assign core_req_ready_o = (count_q != FullCnt);
    assign l15_val_o        = (count_q != '0) && (outstanding_q != MaxOut);
    assign l15_data_o       = mem_q[rd_ptr_q];

    assign enq      = core_req_valid_i && core_req_ready_o;
    assign deq      = l15_val_o && l15_ack_i;
    assign rtrn_err = l15_rtrn_val_i && (outstanding_q == '0);
    assign rtrn_ok  = l15_rtrn_val_i && !rtrn_err;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        err_d         = err_q;

        // Depth is a power of two, so the natural pointer overflow is the wrap.
        if (enq) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (deq) rd_ptr_d = rd_ptr_q + PtrW'(1);

        unique case ({enq, deq})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        // A stray return never decrements; it only raises the sticky error.
        unique case ({deq, rtrn_ok})
            2'b10:   outstanding_d = outstanding_q + OutW'(1);
            2'b01:   outstanding_d = outstanding_q - OutW'(1);
            default: outstanding_d = outstanding_q;
        endcase

        if (rtrn_err) err_d = 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
        end
    end

    // NOTE: payload storage is deliberately not reset; occupancy alone says what is valid.
    always_ff @(posedge clk_i) begin
        if (enq) mem_q[wr_ptr_q] <= core_req_data_i;
    end

    assign count_o       = count_q;
    assign outstanding_o = outstanding_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_lagarto_l15_req_buffer.sv
// Scoreboarded bench for lagarto_l15_req_buffer: payloads are queued at enqueue
// and compared in order when the L1.5 side acks.
module tb_lagarto_l15_req_buffer;

    localparam int DW = 16;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          core_req_valid_i = 1'b0;
    logic          core_req_ready_o;
    logic [DW-1:0] core_req_data_i = '0;
    logic          l15_val_o;
    logic [DW-1:0] l15_data_o;
    logic          l15_ack_i = 1'b0;
    logic          l15_rtrn_val_i = 1'b0;
    logic [2:0]    count_o;
    logic [1:0]    outstanding_o;
    logic          err_o;

    int n_cmp = 0;
    int n_mis = 0;
    int n_deq = 0;
    logic [DW-1:0] sb[$];

    lagarto_l15_req_buffer #(.DataW(DW), .Depth(4), .MaxOutstanding(2)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .core_req_valid_i (core_req_valid_i),
        .core_req_ready_o (core_req_ready_o),
        .core_req_data_i  (core_req_data_i),
        .l15_val_o        (l15_val_o),
        .l15_data_o       (l15_data_o),
        .l15_ack_i        (l15_ack_i),
        .l15_rtrn_val_i   (l15_rtrn_val_i),
        .count_o          (count_o),
        .outstanding_o    (outstanding_o),
        .err_o            (err_o)
    );

    always #5 clk_i = ~clk_i;

    // Scoreboard monitor: inputs change just after posedge, so negedge sees
    // exactly what the next posedge will act on.
    always @(negedge clk_i) begin
        logic [DW-1:0] exp_d;
        if (rst_ni) begin
            if (core_req_valid_i && core_req_ready_o) sb.push_back(core_req_data_i);
            if (l15_val_o && l15_ack_i) begin
                n_cmp++;
                n_deq++;
                if (sb.size() == 0) begin
                    n_mis++;
                    $display("FAIL sb_order: issued %h but nothing was expected", l15_data_o);
                end else begin
                    exp_d = sb.pop_front();
                    if (l15_data_o !== exp_d) begin
                        n_mis++;
                        $display("FAIL sb_order: issued %h expected %h", l15_data_o, exp_d);
                    end
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic a, input logic r);
        core_req_valid_i = v;
        core_req_data_i  = d;
        l15_ack_i        = a;
        l15_rtrn_val_i   = r;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if (core_req_ready_o !== 1'b1 || l15_val_o !== 1'b0 || count_o !== 3'd0 ||
            outstanding_o !== 2'd0 || err_o !== 1'b0) begin
            n_mis++;
            $display("FAIL reset_vals: rdy=%b val=%b cnt=%0d out=%0d err=%b want 1 0 0 0 0",
                     core_req_ready_o, l15_val_o, count_o, outstanding_o, err_o);
        end
        step();
        step();
        rst_ni = 1'b1;
        step();
    endtask

    task automatic test_basic();
        drive(1'b1, 16'h0011, 1'b0, 1'b0);
        n_cmp++;
        if (l15_val_o !== 1'b0) begin
            n_mis++; $display("FAIL basic_no_bypass: val=%b want 0", l15_val_o);
        end
        step();
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
        n_cmp++;
        if (l15_val_o !== 1'b1 || l15_data_o !== 16'h0011) begin
            n_mis++; $display("FAIL basic_issue: val=%b data=%h want 1 0011", l15_val_o, l15_data_o);
        end
        step();
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        n_cmp++;
        if (outstanding_o !== 2'd1 || count_o !== 3'd0 || l15_val_o !== 1'b0) begin
            n_mis++; $display("FAIL basic_acked: out=%0d cnt=%0d val=%b want 1 0 0",
                              outstanding_o, count_o, l15_val_o);
        end
        step();
        drive(1'b0, 16'h0000, 1'b0, 1'b1);
        step();
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        n_cmp++;
        if (outstanding_o !== 2'd0 || err_o !== 1'b0) begin
            n_mis++; $display("FAIL basic_return: out=%0d err=%b want 0 0", outstanding_o, err_o);
        end
    endtask

    task automatic test_fill();
        int  base;
        logic pending;
        logic took;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, DW'(i), 1'b0, 1'b0);
            step();
        end
        drive(1'b1, 16'h0005, 1'b0, 1'b0);
        n_cmp++;
        if (core_req_ready_o !== 1'b0 || count_o !== 3'd4 || l15_data_o !== 16'h0001) begin
            n_mis++; $display("FAIL fill_full: rdy=%b cnt=%0d head=%h want 0 4 0001",
                              core_req_ready_o, count_o, l15_data_o);
        end
        step();
        n_cmp++;
        if (count_o !== 3'd4 || core_req_ready_o !== 1'b0) begin
            n_mis++; $display("FAIL fill_held: cnt=%0d rdy=%b want 4 0", count_o, core_req_ready_o);
        end
        base = n_deq;
        pending = 1'b1;
        for (int c = 0; c < 20 && (n_deq - base) < 5; c++) begin
            drive(pending, 16'h0005, 1'b1, outstanding_o != 2'd0);
            took = pending && core_req_ready_o;
            step();
            if (took) pending = 1'b0;
        end
        n_cmp++;
        if ((n_deq - base) != 5 || sb.size() != 0) begin
            n_mis++; $display("FAIL fill_drain: issued %0d left %0d want 5 0", n_deq - base, sb.size());
        end
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        for (int c = 0; c < 4 && outstanding_o != 2'd0; c++) begin
            drive(1'b0, 16'h0000, 1'b0, 1'b1);
            step();
        end
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        n_cmp++;
        if (count_o !== 3'd0 || outstanding_o !== 2'd0 || err_o !== 1'b0) begin
            n_mis++; $display("FAIL fill_idle: cnt=%0d out=%0d err=%b want 0 0 0",
                              count_o, outstanding_o, err_o);
        end
    endtask

    task automatic test_limit();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'h0021 + DW'(i), 1'b0, 1'b0);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 16'h0000, 1'b1, 1'b0);
            step();
        end
        n_cmp++;
        if (l15_val_o !== 1'b0 || count_o !== 3'd1 || outstanding_o !== 2'd2) begin
            n_mis++; $display("FAIL limit_stall: val=%b cnt=%0d out=%0d want 0 1 2",
                              l15_val_o, count_o, outstanding_o);
        end
        drive(1'b0, 16'h0000, 1'b0, 1'b1);
        step();
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
        n_cmp++;
        if (l15_val_o !== 1'b1 || outstanding_o !== 2'd1 || l15_data_o !== 16'h0023) begin
            n_mis++; $display("FAIL limit_resume: val=%b out=%0d data=%h want 1 1 0023",
                              l15_val_o, outstanding_o, l15_data_o);
        end
        step();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 16'h0000, 1'b0, 1'b1);
            step();
        end
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        n_cmp++;
        if (outstanding_o !== 2'd0 || count_o !== 3'd0 || err_o !== 1'b0) begin
            n_mis++; $display("FAIL limit_idle: out=%0d cnt=%0d err=%b want 0 0 0",
                              outstanding_o, count_o, err_o);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 16'h0031, 1'b0, 1'b0);
        step();
        drive(1'b1, 16'h0032, 1'b1, 1'b0);
        step();
        drive(1'b1, 16'h0033, 1'b0, 1'b0);
        step();
        n_cmp++;
        if (count_o !== 3'd2 || outstanding_o !== 2'd1) begin
            n_mis++; $display("FAIL simul_setup: cnt=%0d out=%0d want 2 1", count_o, outstanding_o);
        end
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 16'h0040 + DW'(i), 1'b1, 1'b1);
            step();
            n_cmp++;
            if (count_o !== 3'd2 || outstanding_o !== 2'd1 || l15_val_o !== 1'b1) begin
                n_mis++; $display("FAIL simul_cycle%0d: cnt=%0d out=%0d val=%b want 2 1 1",
                                  i, count_o, outstanding_o, l15_val_o);
            end
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 16'h0000, 1'b1, 1'b1);
            step();
        end
        drive(1'b0, 16'h0000, 1'b0, 1'b1);
        step();
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        n_cmp++;
        if (count_o !== 3'd0 || outstanding_o !== 2'd0 || sb.size() != 0) begin
            n_mis++; $display("FAIL simul_drain: cnt=%0d out=%0d left=%0d want 0 0 0",
                              count_o, outstanding_o, sb.size());
        end
    endtask

    task automatic test_error();
        drive(1'b0, 16'h0000, 1'b0, 1'b1);
        step();
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        n_cmp++;
        if (err_o !== 1'b1 || outstanding_o !== 2'd0) begin
            n_mis++; $display("FAIL err_set: err=%b out=%0d want 1 0", err_o, outstanding_o);
        end
        step();
        step();
        drive(1'b1, 16'h0055, 1'b0, 1'b0);
        step();
        drive(1'b0, 16'h0000, 1'b1, 1'b1);
        step();
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        n_cmp++;
        if (err_o !== 1'b1 || outstanding_o !== 2'd1) begin
            n_mis++; $display("FAIL err_sticky: err=%b out=%0d want 1 1", err_o, outstanding_o);
        end
        drive(1'b0, 16'h0000, 1'b0, 1'b1);
        step();
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        n_cmp++;
        if (outstanding_o !== 2'd0 || err_o !== 1'b1) begin
            n_mis++; $display("FAIL err_traffic: out=%0d err=%b want 0 1", outstanding_o, err_o);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 16'h0061, 1'b0, 1'b0);
        step();
        drive(1'b1, 16'h0062, 1'b1, 1'b0);
        step();
        drive(1'b1, 16'h0063, 1'b0, 1'b0);
        step();
        drive(1'b1, 16'h0064, 1'b0, 1'b0);
        step();
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        n_cmp++;
        if (count_o !== 3'd3 || outstanding_o !== 2'd1) begin
            n_mis++; $display("FAIL rstmid_setup: cnt=%0d out=%0d want 3 1", count_o, outstanding_o);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        n_cmp++;
        if (core_req_ready_o !== 1'b1 || l15_val_o !== 1'b0 || count_o !== 3'd0 ||
            outstanding_o !== 2'd0 || err_o !== 1'b0) begin
            n_mis++;
            $display("FAIL rstmid_async: rdy=%b val=%b cnt=%0d out=%0d err=%b want 1 0 0 0 0",
                     core_req_ready_o, l15_val_o, count_o, outstanding_o, err_o);
        end
        sb.delete();
        step();
        rst_ni = 1'b1;
        drive(1'b1, 16'h00AA, 1'b0, 1'b0);
        step();
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
        n_cmp++;
        if (l15_val_o !== 1'b1 || l15_data_o !== 16'h00AA || count_o !== 3'd1) begin
            n_mis++; $display("FAIL rstmid_first: val=%b data=%h cnt=%0d want 1 00aa 1",
                              l15_val_o, l15_data_o, count_o);
        end
        step();
        drive(1'b0, 16'h0000, 1'b0, 1'b1);
        step();
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        n_cmp++;
        if (outstanding_o !== 2'd0 || count_o !== 3'd0 || err_o !== 1'b0) begin
            n_mis++; $display("FAIL rstmid_done: out=%0d cnt=%0d err=%b want 0 0 0",
                              outstanding_o, count_o, err_o);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_fill();
        test_limit();
        test_back_to_back();
        test_error();
        test_reset_mid();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/lagarto_l15_req_buffer.md
# lagarto_l15_req_buffer

Request buffer and outstanding-transaction limiter between the Lagarto core memory interface and the OpenPiton L1.5. It queues core requests in a small FIFO and presents the head to the L1.5 using the val/ack protocol. It counts issued-but-unreturned transactions and stops issuing at a configurable limit. It sits directly downstream of the core's L1.5 request output and upstream of the L1.5 request port on the tile.

## Interface
- `DataW`, default 128: request payload width in bits, an opaque flattened request.
- `Depth`, default 4: FIFO entries; must be a power of two and ≥2.
- `MaxOutstanding`, default 2: maximum number of acked requests still awaiting a return; must be ≥1.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `core_req_valid_i` in 1: the core offers a request.
- `core_req_ready_o` out 1: the buffer can accept a request.
- `core_req_data_i` in DataW: request payload.
- `l15_val_o` out 1: the head request is presented to the L1.5.
- `l15_data_o` out DataW: head payload.
- `l15_ack_i` in 1: the L1.5 accepted the presented request.
- `l15_rtrn_val_i` in 1: one return, for a previously acked request, arrives from the L1.5.
- `count_o` out $clog2(Depth+1): FIFO occupancy.
- `outstanding_o` out $clog2(MaxOutstanding+1): acked requests awaiting a return.
- `err_o` out 1: sticky protocol error, set by a return arriving with no request outstanding.

## Operation
- **FIFO structure.** Circular buffer with read and write pointers of $clog2(Depth) bits, plus an occupancy counter `count_q`.
  - Both pointers wrap from Depth-1 to 0.
- **Enqueue.**
  - `core_req_ready_o` = (`count_q` != Depth).
  - An enqueue happens when `core_req_valid_i` && `core_req_ready_o`: the payload is written at the write pointer and the write pointer advances.
- **Issue.**
  - `l15_val_o` = (`count_q` != 0) && (`outstanding_q` != MaxOutstanding).
  - `l15_data_o` is always the entry at the read pointer.
  - A dequeue happens when `l15_val_o` && `l15_ack_i`: the read pointer advances.
  - `l15_ack_i` while `l15_val_o` is low is ignored.
- **Occupancy.**
  - `count_q` increments on enqueue only and decrements on dequeue only.
  - It is unchanged on simultaneous enqueue and dequeue.
- **Full.** When full, `core_req_ready_o` is low even if a dequeue happens in the same cycle; there is no pass-through.
- **Empty.** When empty there is no bypass: an enqueued request first becomes visible on `l15_val_o` the following cycle.
- **Outstanding counter `outstanding_q`.**
  - +1 on dequeue.
  - −1 on `l15_rtrn_val_i`.
  - Unchanged when both happen in the same cycle.
- **Error case.** If `l15_rtrn_val_i` arrives while `outstanding_q` == 0:
  - `err_o` sets and stays set until reset.
  - The return is ignored: the next `outstanding_q` = 0 + dequeue.
- **Payload.** The payload is never modified; request ordering to the L1.5 is strictly FIFO.
- **Outputs.** `count_o` = `count_q`, `outstanding_o` = `outstanding_q`, `err_o` = the sticky flag, all direct register outputs.

## Timing
- Reset (`rst_ni` low, asynchronous) clears the pointers, `count_q`, `outstanding_q` and `err_o`. Storage contents are not reset.
- Reset values of the outputs:
  - `core_req_ready_o` = 1.
  - `l15_val_o` = 0.
  - `l15_data_o` = don't-care; it is X-safe only when `l15_val_o` = 1.
  - `count_o` = 0, `outstanding_o` = 0, `err_o` = 0.
- Reset mid-operation: all queued requests and outstanding tracking are discarded immediately.
  - After release, the first accepted request issues with the normal latency.
- Latency from enqueue to `l15_val_o` is 1 cycle.
  - Back-to-back acks sustain 1 request per cycle while the FIFO is non-empty and the outstanding limit is not reached.
- Once asserted, `l15_val_o` and `l15_data_o` stay stable until acked, unless a reset occurs.
  - Returns only decrease `outstanding_q`, so val cannot drop.
- When `outstanding_q` reaches MaxOutstanding, `l15_val_o` falls in the cycle after the ack.
  - A return brings it back in the cycle after the return.
- Paths to `core_req_ready_o` and `l15_val_o` are combinational from registers only, with no input-to-output paths.

## Test plan
- **Basic flow.** Reset, enqueue A=0x11, ack in the next cycle, return 2 cycles later.
  - `l15_val_o` is high 1 cycle after the enqueue with data 0x11.
  - `outstanding_o` goes 0→1→0.
  - `err_o` = 0.
- **Fill.** Hold `l15_ack_i` low and enqueue 5 requests (0x1..0x5) with Depth=4.
  - `core_req_ready_o` drops after the 4th enqueue; 0x5 is held off and `count_o` = 4.
  - With back-to-back acks and returns in the same cycle as each ack, data emerges 0x1, 0x2, 0x3, 0x4, then 0x5.
- **Outstanding limit.** With MaxOutstanding=2, queue 3 requests, ack every cycle, and send no returns.
  - Two issues complete, then `l15_val_o` = 0 with `count_o` = 1 and `outstanding_o` = 2.
  - One return re-enables `l15_val_o` in the next cycle.
- **Simultaneous events.** With `count_o` = 2 and `outstanding_o` = 1, apply enqueue, ack and return in the same cycle.
  - `count_o` stays 2 and `outstanding_o` stays 1.
  - The pointers wrap correctly across 8+ such cycles.
- **Protocol error.** Pulse `l15_rtrn_val_i` with `outstanding_o` = 0.
  - `err_o` = 1 in the next cycle and stays 1.
  - `outstanding_o` stays 0.
  - Normal traffic continues unaffected.
- **Reset mid-operation.** Queue 3 requests with 1 outstanding, then pulse `rst_ni` low asynchronously.
  - All outputs return to their reset values before the next clock edge.
  - After release, a new request 0xAA issues first.
